// File: rtl/periph_bus_bridge_pkg.sv
// Shared constants for the peripheral bus bridge and its neighbours.
//   - host/slave bus widths and access-size encodings
//   - default bridge geometry (slot count, slot window, timeout)
//   - slot index assignments for the MCU peripherals
//   - bridge FSM state encodings
package periph_bus_bridge_pkg;

  localparam int BUS_WIDTH     = 32;
  localparam int BUS_ACC_WIDTH = 2;

  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'b00;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'b01;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'b10;

  localparam int PB_NSLV = 4;
  localparam int PB_SAW  = 8;
  localparam int PB_TMO  = 15;

  localparam int PB_SLOT_TMR  = 0;
  localparam int PB_SLOT_UART = 1;
  localparam int PB_SLOT_GPIO = 2;
  localparam int PB_SLOT_SPI  = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/periph_addr_decode.sv
// Combinational address decoder for the peripheral bridge.
//   h_addr : host address
//   hit    : address falls inside the NSLV * 2**SAW byte peripheral region at BASE
//   idx    : slot number selected by the bits just above the slot window
module periph_addr_decode #(
  parameter int             NSLV = 4,
  parameter int             HAW  = 32,
  parameter int             SAW  = 8,
  parameter logic [HAW-1:0] BASE = '0
) (
  input  logic [HAW-1:0]           h_addr,
  output logic                     hit,
  output logic [$clog2(NSLV)-1:0]  idx
);

  localparam int IW = $clog2(NSLV);

  // BASE is aligned to the whole region, so only the bits above the
  // slot-index field take part in the match.
  assign hit = (h_addr[HAW-1:SAW+IW] == BASE[HAW-1:SAW+IW]);
  assign idx = h_addr[SAW +: IW];

endmodule

// File: rtl/periph_bus_bridge.sv
// Single-master fan-out bridge in front of the MCU peripheral controllers.
// Decodes each host request to one slave slot, tracks the one outstanding
// transfer and folds decode miss, slave fault, busy and timeout into h_fault.
//
// Handshake: h_req is a one-cycle request pulse. It is taken when the bridge
// is idle or when the current slot's s_resp arrives in the same cycle; the
// chosen s_req bit rises in that same cycle. h_resp is a one-cycle pulse that
// carries h_rdata; h_fault is a one-cycle pulse that ends the request instead.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   h_addr/h_w_rb/h_acc/h_wdata/h_req   host request
//   h_rdata/h_resp/h_fault     host completion
//   s_addr/s_w_rb/s_acc/s_wdata         broadcast to every slot (wires)
//   s_req                      one-hot slot request
//   s_rdata/s_resp/s_fault     per-slot return, slot i at [i*BUS_WIDTH +: BUS_WIDTH]
//   dbg_state, dbg_cnt         FSM state and wait counter
module periph_bus_bridge
  import periph_bus_bridge_pkg::*;
#(
  parameter int             NSLV = PB_NSLV,
  parameter int             HAW  = 32,
  parameter int             SAW  = PB_SAW,
  parameter logic [HAW-1:0] BASE = '0,
  parameter int             TMO  = PB_TMO
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [HAW-1:0]                h_addr,
  input  logic                          h_w_rb,
  input  logic [BUS_ACC_WIDTH-1:0]      h_acc,
  input  logic [BUS_WIDTH-1:0]          h_wdata,
  input  logic                          h_req,
  output logic [BUS_WIDTH-1:0]          h_rdata,
  output logic                          h_resp,
  output logic                          h_fault,
  output logic [SAW-1:0]                s_addr,
  output logic                          s_w_rb,
  output logic [BUS_ACC_WIDTH-1:0]      s_acc,
  output logic [BUS_WIDTH-1:0]          s_wdata,
  output logic [NSLV-1:0]               s_req,
  input  logic [NSLV*BUS_WIDTH-1:0]     s_rdata,
  input  logic [NSLV-1:0]               s_resp,
  input  logic [NSLV-1:0]               s_fault,
  output logic [0:0]                    dbg_state,
  output logic [7:0]                    dbg_cnt
);

  localparam int IW = $clog2(NSLV);
  localparam int BW = BUS_WIDTH;
  // The timeout flag is registered, so the counter gives up one cycle early:
  // the fault pulse then lands exactly TMO cycles after the request cycle.
  localparam logic [7:0] CNT_LAST = (TMO >= 2) ? 8'(TMO - 2) : 8'd0;

  logic [0:0]    state;
  logic [IW-1:0] cur;
  logic [7:0]    cnt;
  logic          tmo_q;

  logic          hit;
  logic [IW-1:0] idx;

  periph_addr_decode #(
    .NSLV (NSLV),
    .HAW  (HAW),
    .SAW  (SAW),
    .BASE (BASE)
  ) u_decode (
    .h_addr (h_addr),
    .hit    (hit),
    .idx    (idx)
  );

  logic in_wait;
  logic resp_cur;
  logic accept;
  logic busy;
  logic sf;
  logic launch;

  always_comb begin
    in_wait  = (state == ST_WAIT);
    resp_cur = s_resp[cur];
    accept   = h_req & (~in_wait | resp_cur);
    busy     = h_req & in_wait & ~resp_cur;
    sf       = s_fault[idx];
    launch   = accept & hit & ~sf;
  end

  assign s_addr  = h_addr[SAW-1:0];
  assign s_w_rb  = h_w_rb;
  assign s_acc   = h_acc;
  assign s_wdata = h_wdata;

  assign s_req   = (accept & hit) ? ({{(NSLV-1){1'b0}}, 1'b1} << idx) : '0;

  assign h_resp  = in_wait & resp_cur;
  assign h_rdata = s_rdata[int'(cur)*BW +: BW];
  assign h_fault = (accept & ~hit) | (accept & hit & sf) | busy | tmo_q;

  assign dbg_state = state;
  assign dbg_cnt   = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cur   <= '0;
      cnt   <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      if (launch) begin
        state <= ST_WAIT;
        cur   <= idx;
        cnt   <= '0;
      end else if (accept) begin
        // miss or slave fault (possibly on a back-to-back completion)
        state <= ST_IDLE;
        cnt   <= '0;
      end else if (in_wait) begin
        if (resp_cur) begin
          state <= ST_IDLE;
          cnt   <= '0;
        end else if (cnt == CNT_LAST) begin
          state <= ST_IDLE;
          cnt   <= '0;
          tmo_q <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_periph_bus_bridge.sv
module tb_periph_bus_bridge;
  import periph_bus_bridge_pkg::*;

  localparam int             NSLV = 4;
  localparam int             HAW  = 32;
  localparam int             SAW  = 8;
  localparam int             TMO  = 15;
  localparam int             BW   = BUS_WIDTH;
  localparam logic [HAW-1:0] BASE = 32'h4000_0000;
  localparam logic [HAW-1:0] REGION = HAW'(NSLV * (2 ** SAW));

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [HAW-1:0]           h_addr = '0;
  logic                     h_w_rb = 1'b0;
  logic [BUS_ACC_WIDTH-1:0] h_acc = BUS_ACC_4B;
  logic [BW-1:0]            h_wdata = '0;
  logic                     h_req = 1'b0;
  logic [BW-1:0]            h_rdata;
  logic                     h_resp;
  logic                     h_fault;
  logic [SAW-1:0]           s_addr;
  logic                     s_w_rb;
  logic [BUS_ACC_WIDTH-1:0] s_acc;
  logic [BW-1:0]            s_wdata;
  logic [NSLV-1:0]          s_req;
  logic [NSLV*BW-1:0]       s_rdata = '0;
  logic [NSLV-1:0]          s_resp = '0;
  logic [NSLV-1:0]          s_fault = '0;
  logic [0:0]               dbg_state;
  logic [7:0]               dbg_cnt;

  periph_bus_bridge #(
    .NSLV (NSLV), .HAW (HAW), .SAW (SAW), .BASE (BASE), .TMO (TMO)
  ) dut (
    .clk (clk), .rst (rst),
    .h_addr (h_addr), .h_w_rb (h_w_rb), .h_acc (h_acc), .h_wdata (h_wdata), .h_req (h_req),
    .h_rdata (h_rdata), .h_resp (h_resp), .h_fault (h_fault),
    .s_addr (s_addr), .s_w_rb (s_w_rb), .s_acc (s_acc), .s_wdata (s_wdata), .s_req (s_req),
    .s_rdata (s_rdata), .s_resp (s_resp), .s_fault (s_fault),
    .dbg_state (dbg_state), .dbg_cnt (dbg_cnt)
  );

  // ---------------- slave models ----------------
  // Slot 0 is a down-counting timer; slots 1..3 are small memories.
  // lat[i] = cycles from s_req to s_resp; 0 means the slot never answers.
  int            lat [NSLV];
  int            pend [NSLV];
  logic [SAW-1:0] radr [NSLV];
  logic [BW-1:0] mem [NSLV][256];
  logic [BW-1:0] tmr = '0;

  always @(posedge clk) begin
    for (int i = 0; i < NSLV; i++) begin
      if (s_req[i] && !s_fault[i]) begin
        pend[i] = lat[i];
        radr[i] = s_addr;
        if (s_w_rb && i != 0) mem[i][s_addr] = s_wdata;
      end
    end
    if (s_req[0] && s_w_rb && !s_fault[0]) tmr = s_wdata;
    else if (tmr != '0) tmr = tmr - 1;
  end

  always @(negedge clk) begin
    s_resp = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (pend[i] > 0) begin
        pend[i] = pend[i] - 1;
        if (pend[i] == 0) begin
          s_resp[i] = 1'b1;
          s_rdata[i*BW +: BW] = (i == 0) ? tmr : mem[i][radr[i]];
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int            checks = 0;
  int            errors = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] ref_mem [NSLV][256];

  // ---------------- driver tasks ----------------
  task automatic req(input logic [HAW-1:0] a, input logic w, input logic [BW-1:0] d);
    @(negedge clk);
    h_addr = a; h_w_rb = w; h_wdata = d; h_acc = BUS_ACC_4B; h_req = 1'b1;
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    h_req = 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; h_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (h_resp !== 1'b0) begin errors++; $display("FAIL rst_resp: got %b expected 0", h_resp); end
    checks++; if (h_fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b expected 0", h_fault); end
    checks++; if (s_req !== 4'b0000) begin errors++; $display("FAIL rst_sreq: got %b expected 0000", s_req); end
    checks++; if (dbg_state !== ST_IDLE || dbg_cnt !== 8'd0) begin errors++; $display("FAIL rst_state: got %b/%0d expected IDLE/0", dbg_state, dbg_cnt); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_timer();
    lat[0] = 1;
    req(BASE, 1'b1, 32'h64);
    checks++; if (s_req !== 4'b0001) begin errors++; $display("FAIL tmr_wr_sreq: got %b expected 0001", s_req); end
    checks++; if (s_wdata !== 32'h64 || s_w_rb !== 1'b1) begin errors++; $display("FAIL tmr_bcast: got %h/%b expected 64/1", s_wdata, s_w_rb); end
    cyc();
    checks++; if (h_resp !== 1'b1) begin errors++; $display("FAIL tmr_wr_resp: got %b expected 1", h_resp); end
    req(BASE, 1'b0, 32'h0);
    checks++; if (s_req !== 4'b0001 || h_resp !== 1'b0) begin errors++; $display("FAIL tmr_rd_sreq: got %b/%b expected 0001/0", s_req, h_resp); end
    exp_q.push_back(32'h62);
    cyc();
    checks++; if (h_resp !== 1'b1) begin errors++; $display("FAIL tmr_rd_resp: got %b expected 1", h_resp); end
    checks++; if (h_rdata !== exp_q.pop_front()) begin errors++; $display("FAIL tmr_rd_data: got %h expected 62", h_rdata); end
  endtask

  task automatic test_miss();
    req(BASE + 32'h400, 1'b0, 32'h0);
    checks++; if (h_fault !== 1'b1 || s_req !== 4'b0000) begin errors++; $display("FAIL miss: got fault %b sreq %b expected 1/0000", h_fault, s_req); end
    cyc();
    checks++; if (dbg_state !== ST_IDLE || h_fault !== 1'b0) begin errors++; $display("FAIL miss_after: got state %b fault %b expected IDLE/0", dbg_state, h_fault); end
  endtask

  task automatic test_slave_fault();
    logic [BW-1:0] d;
    d = $urandom();
    s_fault = 4'b0100; lat[1] = 2;
    req(BASE + 32'h200, 1'b0, 32'h0);
    checks++; if (s_req !== 4'b0100 || h_fault !== 1'b1 || h_resp !== 1'b0) begin errors++; $display("FAIL sfault: got sreq %b fault %b resp %b expected 0100/1/0", s_req, h_fault, h_resp); end
    req(BASE + 32'h104, 1'b1, d);
    ref_mem[1][8'h04] = d;
    checks++; if (s_req !== 4'b0010 || h_fault !== 1'b0) begin errors++; $display("FAIL sfault_next: got sreq %b fault %b expected 0010/0", s_req, h_fault); end
    cyc();
    checks++; if (h_resp !== 1'b0) begin errors++; $display("FAIL sfault_early: got %b expected 0", h_resp); end
    cyc();
    checks++; if (h_resp !== 1'b1) begin errors++; $display("FAIL sfault_resp: got %b expected 1", h_resp); end
    s_fault = '0;
  endtask

  task automatic test_timeout();
    lat[3] = 0; lat[1] = 2;
    req(BASE + 32'h300, 1'b0, 32'h0);
    checks++; if (s_req !== 4'b1000) begin errors++; $display("FAIL tmo_sreq: got %b expected 1000", s_req); end
    for (int c = 1; c < TMO; c++) begin
      cyc();
      checks++; if (h_fault !== 1'b0 || h_resp !== 1'b0) begin errors++; $display("FAIL tmo_early c%0d: got fault %b resp %b expected 0/0", c, h_fault, h_resp); end
    end
    req(BASE + 32'h108, 1'b0, 32'h0);
    exp_q.push_back(ref_mem[1][8'h08]);
    checks++; if (h_fault !== 1'b1) begin errors++; $display("FAIL tmo_fault: got %b expected 1", h_fault); end
    checks++; if (s_req !== 4'b0010) begin errors++; $display("FAIL tmo_accept: got %b expected 0010", s_req); end
    cyc();
    checks++; if (h_fault !== 1'b0) begin errors++; $display("FAIL tmo_pulse: got %b expected 0", h_fault); end
    cyc();
    checks++; if (h_resp !== 1'b1 || h_rdata !== exp_q.pop_front()) begin errors++; $display("FAIL tmo_next_resp: got %b/%h expected 1/data", h_resp, h_rdata); end
  endtask

  task automatic test_back_to_back();
    lat[0] = 1; lat[1] = 3;
    req(BASE, 1'b0, 32'h0);
    req(BASE + 32'h100, 1'b0, 32'h0);
    exp_q.push_back(ref_mem[1][8'h00]);
    checks++; if (h_resp !== 1'b1 || s_req !== 4'b0010 || h_fault !== 1'b0) begin errors++; $display("FAIL b2b: got resp %b sreq %b fault %b expected 1/0010/0", h_resp, s_req, h_fault); end
    req(BASE + 32'h200, 1'b0, 32'h0);
    checks++; if (h_fault !== 1'b1 || s_req !== 4'b0000 || h_resp !== 1'b0) begin errors++; $display("FAIL busy: got fault %b sreq %b resp %b expected 1/0000/0", h_fault, s_req, h_resp); end
    cyc();
    checks++; if (h_fault !== 1'b0 || h_resp !== 1'b0) begin errors++; $display("FAIL busy_after: got fault %b resp %b expected 0/0", h_fault, h_resp); end
    cyc();
    checks++; if (h_resp !== 1'b1 || h_rdata !== exp_q.pop_front()) begin errors++; $display("FAIL b2b_resp: got %b/%h expected 1/data", h_resp, h_rdata); end
  endtask

  task automatic test_reset_in_wait();
    lat[1] = 3;
    req(BASE + 32'h100, 1'b0, 32'h0);
    @(negedge clk); h_req = 1'b0; rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (dbg_state !== ST_IDLE || dbg_cnt !== 8'd0) begin errors++; $display("FAIL rwait_state: got %b/%0d expected IDLE/0", dbg_state, dbg_cnt); end
    for (int c = 3; c <= 5; c++) begin
      cyc();
      checks++; if (h_resp !== 1'b0 || h_fault !== 1'b0) begin errors++; $display("FAIL rwait c%0d: got resp %b fault %b expected 0/0", c, h_resp, h_fault); end
    end
  endtask

  // One transfer checked against a model derived from the address map and
  // the per-slot behaviour configured in lat[] and s_fault.
  task automatic xfer(input logic [HAW-1:0] a, input logic w, input logic [BW-1:0] d);
    logic [HAW-1:0]  off;
    logic            hit;
    int              idx;
    int              ev;
    logic            imm;
    logic            ev_fault;
    logic [NSLV-1:0] exp_req;
    off = a - BASE;
    hit = (off < REGION);
    idx = hit ? int'(off / (2 ** SAW)) : 0;
    exp_req = '0;
    if (hit) exp_req[idx] = 1'b1;
    imm = !hit || s_fault[idx];
    req(a, w, d);
    checks++; if (s_req !== exp_req || h_fault !== imm || s_addr !== a[SAW-1:0]) begin errors++; $display("FAIL rnd_req %h: got sreq %b fault %b saddr %h expected %b/%b/%h", a, s_req, h_fault, s_addr, exp_req, imm, a[SAW-1:0]); end
    if (imm) begin
      cyc();
      return;
    end
    if (w) ref_mem[idx][a[SAW-1:0]] = d;
    else exp_q.push_back(ref_mem[idx][a[SAW-1:0]]);
    ev_fault = (lat[idx] == 0);
    ev = ev_fault ? TMO : lat[idx];
    for (int c = 1; c <= ev; c++) begin
      cyc();
      checks++;
      if (h_resp !== (c == ev && !ev_fault) || h_fault !== (c == ev && ev_fault)) begin
        errors++; $display("FAIL rnd_done %h c%0d: got resp %b fault %b expected %b/%b", a, c, h_resp, h_fault, (c == ev && !ev_fault), (c == ev && ev_fault));
      end
    end
    if (!w && !ev_fault) begin
      checks++; if (h_rdata !== exp_q[0]) begin errors++; $display("FAIL rnd_data %h: got %h expected %h", a, h_rdata, exp_q[0]); end
    end
    if (!w) void'(exp_q.pop_front());
  endtask

  task automatic test_random();
    int            kind;
    int            slot;
    logic [HAW-1:0] a;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      slot = $urandom_range(1, 3);
      a = BASE + HAW'(slot * 256) + HAW'($urandom_range(0, 15));
      if (kind == 0) a = BASE + 32'h400 + HAW'($urandom_range(0, 32'hfff));
      else if (kind == 1) a = 32'h8000_0000 | $urandom();
      s_fault = (kind == 2) ? (4'b0001 << slot) : 4'b0000;
      lat[slot] = (kind == 3) ? 0 : $urandom_range(1, TMO - 1);
      xfer(a, 1'(kind > 5 || $urandom_range(0, 1) == 1), $urandom());
    end
    s_fault = '0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < NSLV; i++) begin
      lat[i] = 1; pend[i] = 0; radr[i] = '0;
      for (int j = 0; j < 256; j++) begin
        mem[i][j] = '0;
        ref_mem[i][j] = '0;
      end
    end
    test_reset();
    test_timer();
    test_miss();
    test_slave_fault();
    test_timeout();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
